// File: rtl/pattern_applier_checker.sv
// pattern_applier_checker
// Replays ATPG patterns into a combinational DUT. Each accepted pattern
// drives PI, waits CAPTURE_DLY settle cycles, then strobes the DUT outputs
// and compares them to XPCT under MASK. It accumulates pattern and failure
// counts plus first-failure information.
// Optional feature: define PATTERN_MISR_EN to build a 16-bit response MISR
// (x^16+x^12+x^5+1, Galois form). Without it, misr_sig is tied to zero.
module pattern_applier_checker #(
  parameter int NINPUTS     = 5,
  parameter int NOUTPUTS    = 2,
  parameter int CAPTURE_DLY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic                pat_last,
  input  logic [NINPUTS-1:0]  pat_pi,
  input  logic [NOUTPUTS-1:0] pat_xpct,
  input  logic [NOUTPUTS-1:0] pat_mask,
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pat_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                fail_any,
  output logic [CNT_W-1:0]    first_fail_idx,
  output logic [NOUTPUTS-1:0] first_fail_bits,
  output logic [15:0]         misr_sig
);

  // The settle counter only has to hold CAPTURE_DLY-1; keep at least one bit.
  localparam int SET_W = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t              state;
  logic [NOUTPUTS-1:0] xpct_q;
  logic [NOUTPUTS-1:0] mask_q;
  logic                last_q;
  logic [SET_W-1:0]    settle_cnt;
  logic [NOUTPUTS-1:0] mm;
  logic                run_start;

  // Masked mismatch of the current strobe; only meaningful in MEASURE.
  assign mm = (dut_po ^ xpct_q) & mask_q;

  // A run may only begin from an idle or finished block; start while busy is dropped.
  assign run_start = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef PATTERN_MISR_EN
  logic [15:0] misr_q;
  logic [15:0] misr_next;

  // Galois step: shift with feedback of the outgoing bit, then fold in masked response.
  always_comb begin
    misr_next = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000);
    misr_next = misr_next ^ 16'(dut_po & mask_q);
  end

  assign misr_sig = misr_q;
`else
  assign misr_sig = 16'h0000;
`endif

  // Run control FSM with registered handshake/status outputs and result accumulation.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // every register (including the latched pattern fields) is cleared here.
    if (!rst_n) begin
      state           <= S_IDLE;
      pat_ready       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      dut_pi          <= '0;
      xpct_q          <= '0;
      mask_q          <= '0;
      last_q          <= 1'b0;
      settle_cnt      <= '0;
      pat_cnt         <= '0;
      fail_cnt        <= '0;
      fail_any        <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_bits <= '0;
`ifdef PATTERN_MISR_EN
      misr_q          <= '0;
`endif
    end else if (run_start) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block referring to pre-edge values, independent of statement order.
      state           <= S_LOAD;
      pat_ready       <= 1'b1;
      busy            <= 1'b1;
      done            <= 1'b0;
      pat_cnt         <= '0;
      fail_cnt        <= '0;
      fail_any        <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_bits <= '0;
`ifdef PATTERN_MISR_EN
      misr_q          <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (pat_valid && pat_ready) begin
            xpct_q     <= pat_xpct;
            mask_q     <= pat_mask;
            last_q     <= pat_last;
            dut_pi     <= pat_pi;
            settle_cnt <= SET_W'(CAPTURE_DLY - 1);
            pat_ready  <= 1'b0;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_MEASURE;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        S_MEASURE: begin
          pat_cnt <= pat_cnt + CNT_W'(1);
          if (mm != '0) begin
            if (fail_cnt != '1) begin
              fail_cnt <= fail_cnt + CNT_W'(1);
            end
            fail_any <= 1'b1;
            if (!fail_any) begin
              first_fail_idx  <= pat_cnt;
              first_fail_bits <= mm;
            end
          end
`ifdef PATTERN_MISR_EN
          misr_q <= misr_next;
`endif
          if (last_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_LOAD;
            pat_ready <= 1'b1;
          end
        end
        S_IDLE, S_DONE: begin
          // Waiting for start; outputs hold.
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_applier_checker.sv
// Testbench for pattern_applier_checker: loopback DUT (dut_po = dut_pi[1:0]),
// directed scenarios followed by a randomized run, all checked against a
// pattern-level reference model of counters, first-failure data and MISR.
module tb_pattern_applier_checker;

  localparam int NI = 5;
  localparam int NO = 2;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pat_valid;
  logic          pat_ready;
  logic          pat_last;
  logic [NI-1:0] pat_pi;
  logic [NO-1:0] pat_xpct;
  logic [NO-1:0] pat_mask;
  logic [NI-1:0] dut_pi;
  logic [NO-1:0] dut_po;
  logic          busy;
  logic          done;
  logic [CW-1:0] pat_cnt;
  logic [CW-1:0] fail_cnt;
  logic          fail_any;
  logic [CW-1:0] first_fail_idx;
  logic [NO-1:0] first_fail_bits;
  logic [15:0]   misr_sig;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, updated once per measured pattern.
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_fail;
  logic          m_any;
  logic [CW-1:0] m_ffi;
  logic [NO-1:0] m_ffb;
  logic [15:0]   m_misr;

  pattern_applier_checker #(
    .NINPUTS(NI), .NOUTPUTS(NO), .CAPTURE_DLY(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_last(pat_last),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask),
    .dut_pi(dut_pi), .dut_po(dut_po),
    .busy(busy), .done(done),
    .pat_cnt(pat_cnt), .fail_cnt(fail_cnt), .fail_any(fail_any),
    .first_fail_idx(first_fail_idx), .first_fail_bits(first_fail_bits),
    .misr_sig(misr_sig)
  );

  // Loopback combinational DUT.
  assign dut_po = dut_pi[1:0];

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before 300us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo p(x), add data.
  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [NO-1:0] d);
    int unsigned v;
    v = 32'(s) * 2;
    if (v >= 32'h10000) v = v ^ 32'h11021;
    v = v ^ 32'(d);
    return v[15:0];
  endfunction

  task automatic model_clear();
    m_cnt = '0; m_fail = '0; m_any = 1'b0; m_ffi = '0; m_ffb = '0; m_misr = '0;
  endtask

  task automatic model_update(input logic [NI-1:0] pi, input logic [NO-1:0] xp,
                              input logic [NO-1:0] mk);
    logic [NO-1:0] actual;
    logic [NO-1:0] mmv;
    actual = pi[1:0];
    mmv = (actual ^ xp) & mk;
    if (mmv != 0) begin
      if (!m_any) begin
        m_ffi = m_cnt;
        m_ffb = mmv;
      end
      m_any = 1'b1;
      if (m_fail != 16'hFFFF) m_fail = m_fail + 1;
    end
    m_cnt = m_cnt + 1;
`ifdef PATTERN_MISR_EN
    m_misr = misr_model(m_misr, actual & mk);
`endif
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pat_cnt"},  32'(pat_cnt),         32'(m_cnt));
    check({tag, "_fail_cnt"}, 32'(fail_cnt),        32'(m_fail));
    check({tag, "_fail_any"}, 32'(fail_any),        32'(m_any));
    check({tag, "_ff_idx"},   32'(first_fail_idx),  32'(m_ffi));
    check({tag, "_ff_bits"},  32'(first_fail_bits), 32'(m_ffb));
    check({tag, "_misr"},     32'(misr_sig),        32'(m_misr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pat_ready"}, 32'(pat_ready), 0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_dut_pi"},    32'(dut_pi),    0);
    model_clear();
    check_status(tag);
  endtask

  // Called at a negedge in IDLE or DONE.
  task automatic start_run(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check({tag, "_busy"},      32'(busy),      1);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_pat_ready"}, 32'(pat_ready), 1);
    check_status(tag);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic accept_pattern(input string tag, input logic [NI-1:0] pi,
                                input logic [NO-1:0] xp, input logic [NO-1:0] mk,
                                input logic last);
    int waited = 0;
    while (!pat_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!pat_ready) check({tag, "_ready_timeout"}, 0, 1);
    check({tag, "_busy_load"}, 32'(busy), 1);
    pat_valid = 1'b1;
    pat_pi    = pi;
    pat_xpct  = xp;
    pat_mask  = mk;
    pat_last  = last;
    @(negedge clk);
    pat_valid = 1'b0;
    check({tag, "_dut_pi"},      32'(dut_pi),    32'(pi));
    check({tag, "_ready_low"},   32'(pat_ready), 0);
  endtask

  task automatic run_pattern(input string tag, input logic [NI-1:0] pi,
                             input logic [NO-1:0] xp, input logic [NO-1:0] mk,
                             input logic last, input logic poke_start);
    accept_pattern(tag, pi, xp, mk, last);
    if (poke_start) start = 1'b1;
    repeat (D) begin
      @(negedge clk);
      start = 1'b0;
    end
    // Strobe edge has not happened yet: counters still hold old values.
    check({tag, "_pre_strobe_cnt"}, 32'(pat_cnt), 32'(m_cnt));
    check({tag, "_pre_strobe_busy"}, 32'(busy), 1);
    model_update(pi, xp, mk);
    @(negedge clk);
    check_status(tag);
    check({tag, "_done"},      32'(done),      32'(last));
    check({tag, "_busy"},      32'(busy),      32'(!last));
    check({tag, "_pat_ready"}, 32'(pat_ready), 32'(!last));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; pat_valid = 1'b0; pat_last = 1'b0;
    pat_pi = '0; pat_xpct = '0; pat_mask = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_ready", 32'(pat_ready), 0);

    // Single passing pattern.
    start_run("a_start");
    run_pattern("a", 5'b01101, 2'b01, 2'b11, 1'b1, 1'b0);
`ifdef PATTERN_MISR_EN
    check("a_misr_const", 32'(misr_sig), 32'h0001);
`else
    check("a_misr_const", 32'(misr_sig), 32'h0000);
`endif
    repeat (3) @(negedge clk);
    check("a_done_held", 32'(done), 1);

    // Three patterns, the middle one fails on both bits.
    start_run("b_start");
    run_pattern("b0", 5'b00001, 2'b01, 2'b11, 1'b0, 1'b0);
    run_pattern("b1", 5'b10101, 2'b10, 2'b11, 1'b0, 1'b0);
    run_pattern("b2", 5'b11001, 2'b01, 2'b11, 1'b1, 1'b0);
    check("b_fail_cnt", 32'(fail_cnt), 1);
    check("b_ff_idx", 32'(first_fail_idx), 1);
    check("b_ff_bits", 32'(first_fail_bits), 32'b11);
    check("b_fail_any", 32'(fail_any), 1);

    // Masking: actual 11 vs 10, low bit don't-care then compared.
    start_run("c_start");
    run_pattern("c0", 5'b00011, 2'b10, 2'b10, 1'b0, 1'b0);
    check("c0_pass", 32'(fail_any), 0);
    run_pattern("c1", 5'b00111, 2'b10, 2'b11, 1'b1, 1'b0);
    check("c1_ff_bits", 32'(first_fail_bits), 32'b01);
    check("c1_ff_idx", 32'(first_fail_idx), 1);

    // Stall in LOAD, then start pulse during SETTLE, mask=0 pattern.
    start_run("d_start");
    repeat (7) begin
      @(negedge clk);
      check("d_stall_ready", 32'(pat_ready), 1);
      check("d_stall_dut_pi", 32'(dut_pi), 32'b00111);
    end
    run_pattern("d", 5'b11110, 2'b10, 2'b00, 1'b1, 1'b1);
    check("d_mask0_pass", 32'(fail_any), 0);
    check("d_cnt", 32'(pat_cnt), 1);

    // Randomized run with random gaps.
    start_run("e_start");
    for (int i = 0; i < 40; i++) begin
      logic [NI-1:0] rpi;
      logic [NO-1:0] rxp;
      logic [NO-1:0] rmk;
      rpi = NI'($urandom_range(0, 31));
      rxp = NO'($urandom_range(0, 3));
      rmk = NO'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_pattern("e", rpi, rxp, rmk, (i == 39), 1'b0);
    end

    // Reset during SETTLE of the second pattern.
    start_run("f_start");
    run_pattern("f0", 5'b00000, 2'b11, 2'b11, 1'b0, 1'b0);
    accept_pattern("f1", 5'b10110, 2'b00, 2'b11, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("f_reset");
    repeat (12) begin
      @(negedge clk);
      check("f_no_done", 32'(done), 0);
    end
    check("f_idle_busy", 32'(busy), 0);
    check("f_idle_ready", 32'(pat_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
